riscv_trace_capture: RTL and testbench

- Sits on the processor's debug/observation port, the consuming end of the signals the core exports for bench observation.
- Watches PC_EX, ALU_OUT_EX, PCSrc, forwardA/forwardB and pipeline_stall.
- Waits for a PC trigger, then records per-cycle EX-stage trace records into a FIFO.
- Tracks stall and flush statistics; records are drained through a simple read handshake by a host or bench.

---
 rtl/riscv_trace_capture.sv | 150 +++++++++++++++
 tb/tb_riscv_trace_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_trace_capture.sv
// riscv_trace_capture
//   Observation-side trace buffer for the RISC-V core's debug port. After an
//   arm pulse it waits for a PC trigger (or starts immediately when trig_en=0),
//   then records one 72-bit EX-stage record per qualifying cycle into a FIFO,
//   counting stall and flush cycles along the way. A host drains records
//   through a one-cycle rd_en -> rd_valid handshake.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   arm                 clear buffer and counters, enter ARMED
//   stop                end capture (CAPTURE -> DONE)
//   trig_en, trig_pc    PC trigger enable / trigger PC
//   PC_EX, ALU_OUT_EX   EX-stage PC and ALU result
//   PCSrc               taken branch/jump (flush)
//   pipeline_stall      hazard stall
//   forwardA, forwardB  forwarding selects
//   rd_en               read request
//   rd_data, rd_valid   oldest record, valid for one cycle after rd_en
//   empty, full, count  FIFO occupancy (registered)
//   state               IDLE=0 ARMED=1 CAPTURE=2 DONE=3
//   stall_cnt, flush_cnt saturating statistics over capture cycles
module riscv_trace_capture #(
    parameter int DEPTH         = 16,
    parameter bit FILTER_STALLS = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     trig_en,
    input  logic [31:0]              trig_pc,
    input  logic [31:0]              PC_EX,
    input  logic [31:0]              ALU_OUT_EX,
    input  logic                     PCSrc,
    input  logic                     pipeline_stall,
    input  logic [1:0]               forwardA,
    input  logic [1:0]               forwardB,
    input  logic                     rd_en,
    output logic [71:0]              rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              flush_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          st;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [71:0]     mem [DEPTH];

    logic            qual;
    logic            trig;
    logic            cap;
    logic            wr;
    logic            rd;
    logic [CW-1:0]   cnt_nxt;
    logic [71:0]     rec;

    assign state = st;

    always_comb begin
        qual    = !(FILTER_STALLS && pipeline_stall);
        // A PC match while stalled is not a trigger: the stalled
        // instruction has not really executed yet.
        trig    = (st == ARMED) &&
                  (!trig_en || ((PC_EX == trig_pc) && !pipeline_stall));
        // The trigger cycle behaves exactly like a CAPTURE cycle.
        cap     = (st == CAPTURE) || trig;
        wr      = cap && qual;
        rd      = rd_en && !empty;
        cnt_nxt = count + CW'(wr) - CW'(rd);
        rec     = {PC_EX, ALU_OUT_EX, PCSrc, pipeline_stall,
                   forwardA, forwardB, 2'b00};
    end

    // Record storage; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (!reset && !arm && wr)
            mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (arm) begin
            // arm wins over any read or write in the same cycle.
            st        <= ARMED;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            rd_valid  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            rd_valid <= rd;
            if (rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            count <= cnt_nxt;
            empty <= (cnt_nxt == '0);
            full  <= (cnt_nxt == CW'(DEPTH));

            if (cap) begin
                if (pipeline_stall && (stall_cnt != '1))
                    stall_cnt <= stall_cnt + 32'd1;
                if (PCSrc && (flush_cnt != '1))
                    flush_cnt <= flush_cnt + 32'd1;
            end

            case (st)
                IDLE:    st <= IDLE;
                ARMED:   if (trig) st <= CAPTURE;
                // A same-cycle read keeps count below DEPTH and so extends
                // the capture.
                CAPTURE: if (stop || (wr && (cnt_nxt == CW'(DEPTH))))
                             st <= DONE;
                DONE:    st <= DONE;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_trace_capture.sv
// Directed bench for riscv_trace_capture (DEPTH=16, FILTER_STALLS=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the same point, i.e. they show the result of the edge just taken.
module tb_riscv_trace_capture;

    logic        clk = 1'b0;
    logic        reset, arm, stop, trig_en, PCSrc, pipeline_stall, rd_en;
    logic [31:0] trig_pc, PC_EX, ALU_OUT_EX;
    logic [1:0]  forwardA, forwardB;
    logic [71:0] rd_data;
    logic        rd_valid, empty, full;
    logic [4:0]  count;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    riscv_trace_capture #(.DEPTH(16), .FILTER_STALLS(1'b1)) dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop),
        .trig_en(trig_en), .trig_pc(trig_pc), .PC_EX(PC_EX),
        .ALU_OUT_EX(ALU_OUT_EX), .PCSrc(PCSrc),
        .pipeline_stall(pipeline_stall), .forwardA(forwardA),
        .forwardB(forwardB), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [31:0] pc, input logic stl, input logic psrc);
        PC_EX          = pc;
        ALU_OUT_EX     = pc + 32'h100;
        pipeline_stall = stl;
        PCSrc          = psrc;
        forwardA       = pc[3:2];
        forwardB       = pc[5:4];
        tick;
    endtask

    task automatic do_arm(input logic te, input logic [31:0] tpc);
        arm = 1'b1; trig_en = te; trig_pc = tpc;
        PC_EX = 32'hFFFF_FFF0; pipeline_stall = 1'b0; PCSrc = 1'b0;
        tick;
        arm = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; tick; tick; reset = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d exp 0", state); end
        n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL reset_flags got e=%b f=%b exp e=1 f=0", empty, full); end
        n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 72'd0) begin n_bad++; $display("FAIL reset_rd got v=%b d=%h exp 0", rd_valid, rd_data); end
        n_cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
        rd_en = 1'b1; tick; rd_en = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0 || count !== 5'd0) begin n_bad++; $display("FAIL empty_read got v=%b cnt=%0d exp 0/0", rd_valid, count); end
    endtask

    task automatic test_trigger;
        do_arm(1'b1, 32'h10);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL arm_state got %0d exp 1", state); end
        for (int i = 0; i < 4; i++) begin
            cyc(32'(i * 4), 1'b0, 1'b0);
            n_cmp++; if (state !== 2'd1 || count !== 5'd0) begin n_bad++; $display("FAIL pretrig_%0d got st=%0d cnt=%0d exp 1/0", i, state, count); end
        end
        cyc(32'h10, 1'b0, 1'b0);
        n_cmp++; if (state !== 2'd2 || count !== 5'd1) begin n_bad++; $display("FAIL trig_cycle got st=%0d cnt=%0d exp 2/1", state, count); end
        for (int i = 1; i < 16; i++) cyc(32'h10 + 32'(i * 4), 1'b0, 1'b0);
        n_cmp++; if (state !== 2'd3 || full !== 1'b1 || count !== 5'd16) begin n_bad++; $display("FAIL fill_done got st=%0d f=%b cnt=%0d exp 3/1/16", state, full, count); end
        cyc(32'h50, 1'b0, 1'b0);
        n_cmp++; if (count !== 5'd16 || state !== 2'd3) begin n_bad++; $display("FAIL done_nowrite got st=%0d cnt=%0d exp 3/16", state, count); end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            if (i == 0) begin
                n_cmp++; if (rd_data !== {32'h10, 32'h110, 1'b0, 1'b0, 2'd0, 2'd1, 2'b00}) begin n_bad++; $display("FAIL first_rec got %h exp %h", rd_data, {32'h10, 32'h110, 1'b0, 1'b0, 2'd0, 2'd1, 2'b00}); end
            end
            n_cmp++; if (rd_valid !== 1'b1 || rd_data[71:40] !== 32'h10 + 32'(i * 4)) begin n_bad++; $display("FAIL trig_read_%0d got v=%b pc=%h exp 1/%h", i, rd_valid, rd_data[71:40], 32'h10 + 32'(i * 4)); end
        end
        rd_en = 1'b0; tick;
        n_cmp++; if (empty !== 1'b1 || rd_valid !== 1'b0 || rd_data[71:40] !== 32'h4C) begin n_bad++; $display("FAIL drained got e=%b v=%b pc=%h exp 1/0/4c", empty, rd_valid, rd_data[71:40]); end
    endtask

    task automatic test_trigger_stall;
        do_arm(1'b1, 32'h40);
        cyc(32'h40, 1'b1, 1'b0);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL stall_notrig got %0d exp 1", state); end
        cyc(32'h40, 1'b0, 1'b0);
        n_cmp++; if (state !== 2'd2 || count !== 5'd1 || stall_cnt !== 32'd0) begin n_bad++; $display("FAIL trig_after_stall got st=%0d cnt=%0d sc=%0d exp 2/1/0", state, count, stall_cnt); end
    endtask

    task automatic test_filter;
        logic [5:0]  stl;
        logic [5:0]  ps;
        logic [31:0] exp_pc [4];
        stl = 6'b010010;  // bit i = cycle i
        ps  = 6'b000100;
        exp_pc = '{32'h200, 32'h208, 32'h20C, 32'h214};
        do_arm(1'b0, 32'h0);
        for (int i = 0; i < 6; i++) cyc(32'h200 + 32'(i * 4), stl[i], ps[i]);
        n_cmp++; if (count !== 5'd4 || state !== 2'd2) begin n_bad++; $display("FAIL filt_count got cnt=%0d st=%0d exp 4/2", count, state); end
        n_cmp++; if (stall_cnt !== 32'd2) begin n_bad++; $display("FAIL filt_stall_cnt got %0d exp 2", stall_cnt); end
        n_cmp++; if (flush_cnt !== 32'd1) begin n_bad++; $display("FAIL filt_flush_cnt got %0d exp 1", flush_cnt); end
        pipeline_stall = 1'b1; rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_cmp++; if (rd_valid !== 1'b1 || rd_data[71:40] !== exp_pc[i] || rd_data[6] !== 1'b0) begin n_bad++; $display("FAIL filt_read_%0d got v=%b pc=%h s=%b exp 1/%h/0", i, rd_valid, rd_data[71:40], rd_data[6], exp_pc[i]); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        do_arm(1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cyc(32'h300 + 32'(i * 4), 1'b0, 1'b0);
        n_cmp++; if (count !== 5'd3) begin n_bad++; $display("FAIL b2b_pre got %0d exp 3", count); end
        rd_en = 1'b1;
        cyc(32'h30C, 1'b0, 1'b0);
        rd_en = 1'b0;
        n_cmp++; if (count !== 5'd3 || rd_valid !== 1'b1 || rd_data[71:40] !== 32'h300) begin n_bad++; $display("FAIL b2b_rw got cnt=%0d v=%b pc=%h exp 3/1/300", count, rd_valid, rd_data[71:40]); end
        cyc(32'h310, 1'b1, 1'b0);
        n_cmp++; if (rd_valid !== 1'b0 || rd_data[71:40] !== 32'h300 || count !== 5'd3) begin n_bad++; $display("FAIL b2b_hold got v=%b pc=%h cnt=%0d exp 0/300/3", rd_valid, rd_data[71:40], count); end
    endtask

    task automatic test_stop;
        do_arm(1'b0, 32'h0);
        for (int i = 0; i < 8; i++) cyc(32'h400 + 32'(i * 4), 1'b0, 1'b0);
        n_cmp++; if (count !== 5'd8 || state !== 2'd2) begin n_bad++; $display("FAIL stop_pre got cnt=%0d st=%0d exp 8/2", count, state); end
        stop = 1'b1;
        cyc(32'h420, 1'b0, 1'b0);
        stop = 1'b0;
        n_cmp++; if (count !== 5'd9 || state !== 2'd3) begin n_bad++; $display("FAIL stop_done got cnt=%0d st=%0d exp 9/3", count, state); end
        rd_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick;
            n_cmp++; if (rd_valid !== 1'b1 || rd_data[71:40] !== 32'h400 + 32'(i * 4)) begin n_bad++; $display("FAIL stop_read_%0d got v=%b pc=%h exp 1/%h", i, rd_valid, rd_data[71:40], 32'h400 + 32'(i * 4)); end
        end
        n_cmp++; if (empty !== 1'b1 || count !== 5'd0) begin n_bad++; $display("FAIL stop_empty got e=%b cnt=%0d exp 1/0", empty, count); end
        tick;
        rd_en = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL tenth_read got v=%b exp 0", rd_valid); end
    endtask

    task automatic test_arm_mid;
        do_arm(1'b0, 32'h0);
        cyc(32'h500, 1'b0, 1'b0);
        cyc(32'h504, 1'b1, 1'b0);
        cyc(32'h508, 1'b0, 1'b1);
        cyc(32'h50C, 1'b0, 1'b0);
        cyc(32'h510, 1'b0, 1'b0);
        cyc(32'h514, 1'b0, 1'b0);
        n_cmp++; if (count !== 5'd5 || stall_cnt !== 32'd1 || flush_cnt !== 32'd1) begin n_bad++; $display("FAIL arm_mid_pre got cnt=%0d sc=%0d fc=%0d exp 5/1/1", count, stall_cnt, flush_cnt); end
        arm = 1'b1; rd_en = 1'b1; trig_en = 1'b1; trig_pc = 32'hDEAD_0000;
        tick;
        arm = 1'b0; rd_en = 1'b0;
        n_cmp++; if (state !== 2'd1 || count !== 5'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL arm_mid_state got st=%0d cnt=%0d e=%b exp 1/0/1", state, count, empty); end
        n_cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL arm_mid_clr got sc=%0d fc=%0d v=%b exp 0/0/0", stall_cnt, flush_cnt, rd_valid); end
    endtask

    task automatic test_reset_mid;
        do_arm(1'b0, 32'h0);
        for (int i = 0; i < 7; i++) cyc(32'h700 + 32'(i * 4), 1'b0, 1'b1);
        n_cmp++; if (count !== 5'd7) begin n_bad++; $display("FAIL rst_mid_pre got %0d exp 7", count); end
        reset = 1'b1; tick; reset = 1'b0;
        n_cmp++; if (state !== 2'd0 || count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL rst_mid_state got st=%0d cnt=%0d e=%b f=%b exp 0/0/1/0", state, count, empty, full); end
        n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 72'd0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_mid_out got v=%b d=%h sc=%0d fc=%0d exp 0", rd_valid, rd_data, stall_cnt, flush_cnt); end
    endtask

    task automatic test_saturate;
        do_arm(1'b0, 32'h0);
        cyc(32'h600, 1'b1, 1'b0);
        n_cmp++; if (stall_cnt !== 32'd1 || state !== 2'd2) begin n_bad++; $display("FAIL sat_pre got sc=%0d st=%0d exp 1/2", stall_cnt, state); end
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        cyc(32'h604, 1'b1, 1'b0);
        n_cmp++; if (stall_cnt !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_reach got %h exp ffffffff", stall_cnt); end
        cyc(32'h608, 1'b1, 1'b0);
        n_cmp++; if (stall_cnt !== 32'hFFFF_FFFF || count !== 5'd0) begin n_bad++; $display("FAIL sat_hold got sc=%h cnt=%0d exp ffffffff/0", stall_cnt, count); end
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; stop = 1'b0; trig_en = 1'b0; trig_pc = '0;
        PC_EX = '0; ALU_OUT_EX = '0; PCSrc = 1'b0; pipeline_stall = 1'b0;
        forwardA = '0; forwardB = '0; rd_en = 1'b0;
        test_reset;
        test_trigger;
        test_trigger_stall;
        test_filter;
        test_back_to_back;
        test_stop;
        test_arm_mid;
        test_reset_mid;
        test_saturate;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
